// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle for the load/store unit.
// Request side is a valid/ready handshake; response is a one-cycle valid pulse.
// The master (CPU pipeline) drives req_* and consumes resp_*; the slave is the unit.
interface mem_access_unit_if #(
  parameter int TAG_WIDTH = 5
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;
  logic [TAG_WIDTH-1:0] resp_tag;
  logic                 resp_exc;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_tag,
    input  req_ready, resp_valid, resp_rdata, resp_tag, resp_exc
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_tag,
    output req_ready, resp_valid, resp_rdata, resp_tag, resp_exc
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end: byte-lane enables, lane-replicated store data, extended load data.
// Latency accept->resp_valid: store 2 edges, load 3 edges (misaligned exception 2 edges).
// Backpressure: req_ready only in IDLE, one op in flight; MAU_MISALIGN_EXC_EN enables misalign exceptions.
module mem_access_unit #(
  parameter int TAG_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_unit_if.slave    cpu,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [3:0]          mem_wdata_sel,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [3:0]           sel_q, sel_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic                 we_q, we_d;
  logic                 exc_q, exc_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [31:0]          resp_rdata_q, resp_rdata_d;
  logic [TAG_WIDTH-1:0] resp_tag_q, resp_tag_d;
  logic                 resp_exc_q, resp_exc_d;

  logic [31:0]          req_addr_al;
  logic                 req_misalign;
  logic [3:0]           req_sel;
  logic [31:0]          req_wdata_rep;
  logic [31:0]          ld_shift;
  logic [31:0]          ld_data;
  logic                 store_issue;

  // Decode the incoming request: alignment, misalign flag, lane enables, replicated data.
  always_comb begin
    req_addr_al   = cpu.req_addr;
    req_misalign  = 1'b0;
    req_sel       = 4'b1111;
    req_wdata_rep = cpu.req_wdata;
`ifdef MAU_MISALIGN_EXC_EN
    if (cpu.req_size == 2'b01) begin
      req_misalign = cpu.req_addr[0];
    end else if (cpu.req_size[1]) begin
      req_misalign = |cpu.req_addr[1:0];
    end
`else
    // Without exceptions the low address bits are simply forced aligned.
    if (cpu.req_size == 2'b01) begin
      req_addr_al[0] = 1'b0;
    end else if (cpu.req_size[1]) begin
      req_addr_al[1:0] = 2'b00;
    end
`endif
    case (cpu.req_size)
      2'b00: begin
        req_sel       = 4'b0001 << req_addr_al[1:0];
        req_wdata_rep = {4{cpu.req_wdata[7:0]}};
      end
      2'b01: begin
        req_sel       = req_addr_al[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{cpu.req_wdata[15:0]}};
      end
      default: begin
        req_sel       = 4'b1111;
        req_wdata_rep = cpu.req_wdata;
      end
    endcase
  end

  // Extract and extend the addressed lane from the registered memory read data.
  always_comb begin
    ld_shift = mem_rdata >> {mem_addr_q[1:0], 3'b000};
    ld_data  = ld_shift;
    if (size_q == 2'b00) begin
      ld_data = uns_q ? {24'h0, ld_shift[7:0]} : {{24{ld_shift[7]}}, ld_shift[7:0]};
    end else if (size_q == 2'b01) begin
      ld_data = uns_q ? {16'h0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
    end
  end

  // Next-state and response logic for the IDLE -> ISSUE -> (RDATA) -> IDLE sequence.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    sel_d        = sel_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    exc_d        = exc_q;
    tag_d        = tag_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_tag_d   = resp_tag_q;
    resp_exc_d   = resp_exc_q;
    case (state_q)
      IDLE: begin
        if (cpu.req_valid) begin
          state_d = ISSUE;
          size_d  = cpu.req_size;
          uns_d   = cpu.req_unsigned;
          we_d    = cpu.req_we;
          tag_d   = cpu.req_tag;
          exc_d   = req_misalign;
          // A misaligned op never reaches memory, so the memory bus keeps its last value.
          if (!req_misalign) begin
            mem_addr_d  = req_addr_al;
            mem_wdata_d = req_wdata_rep;
            sel_d       = req_sel;
          end
        end
      end
      ISSUE: begin
        if (exc_q || we_q) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'h0;
          resp_tag_d   = tag_q;
          resp_exc_d   = exc_q;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
        resp_tag_d   = tag_q;
        resp_exc_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request/response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      sel_q        <= 4'h0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      exc_q        <= 1'b0;
      tag_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_tag_q   <= '0;
      resp_exc_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      sel_q        <= sel_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      exc_q        <= exc_d;
      tag_q        <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_tag_q   <= resp_tag_d;
      resp_exc_q   <= resp_exc_d;
    end
  end

  // Write strobes exist only in a real store's ISSUE cycle; rst masks them combinationally
  // so a reset landing on ISSUE can never commit a partial write.
  assign store_issue   = (state_q == ISSUE) & we_q & ~exc_q & ~rst;
  assign mem_we        = store_issue;
  assign mem_wdata_sel = store_issue ? sel_q : 4'h0;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

  assign cpu.req_ready  = (state_q == IDLE);
  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_rdata = resp_rdata_q;
  assign cpu.resp_tag   = resp_tag_q;
  assign cpu.resp_exc   = resp_exc_q;

endmodule
